// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer: assembles WIDTH-bit words from a qualified
// bit stream and hands them off through a one-word valid/ready holding register.
module sipo_deserializer #(
    parameter  int WIDTH     = 8,
    parameter  bit MSB_FIRST = 1'b1,
    localparam int CNT_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             serial_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] bit_count,
    output logic             overrun
);

    logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             word_done;
    logic             hold_free;

    generate
        if (MSB_FIRST) begin : g_msb
            assign sr_shift = {sr_q[WIDTH-2:0], serial_in};
        end else begin : g_lsb
            assign sr_shift = {serial_in, sr_q[WIDTH-1:1]};
        end
    endgenerate

    assign word_done = in_valid && (cnt_q == CNT_W'(WIDTH - 1));
    // A consumer taking the old word in the same cycle frees the slot for the new one.
    assign hold_free = !valid_q || out_ready;

    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (clear) begin
            sr_d    = '0;
            cnt_d   = '0;
            data_d  = '0;
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            if (in_valid) begin
                sr_d  = sr_shift;
                cnt_d = word_done ? '0 : cnt_q + CNT_W'(1);
            end
            if (word_done) begin
                if (hold_free) begin
                    data_d  = sr_shift;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else if (valid_q && out_ready) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign bit_count = cnt_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: MSB-first and LSB-first instances share
// one stimulus stream; delivered words are checked against per-instance queues.
module tb_sipo_deserializer;

    logic       clk = 1'b0;
    logic       reset, clear, in_valid, serial_in, out_ready;
    logic [7:0] data_m, data_l;
    logic       valid_m, valid_l, ovr_m, ovr_l;
    logic [2:0] cnt_m, cnt_l;

    int checks = 0;
    int passes = 0;
    logic [7:0] q_m[$];
    logic [7:0] q_l[$];

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .serial_in(serial_in), .out_data(data_m), .out_valid(valid_m),
        .out_ready(out_ready), .bit_count(cnt_m), .overrun(ovr_m)
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .serial_in(serial_in), .out_data(data_l), .out_valid(valid_l),
        .out_ready(out_ready), .bit_count(cnt_l), .overrun(ovr_l)
    );

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        in_valid  = 1'b1;
        serial_in = b;
        tick(1);
        in_valid  = 1'b0;
    endtask

    // Serial order is always w[7] first; the LSB-first instance therefore sees rev8(w).
    task automatic send_word(input logic [7:0] w, input bit push, input bit ready_last);
        if (push) begin
            q_m.push_back(w);
            q_l.push_back(rev8(w));
        end
        for (int i = 7; i >= 0; i--) begin
            if (i == 0 && ready_last) out_ready = 1'b1;
            send_bit(w[i]);
        end
    endtask

    // Scoreboard: every handshake must deliver the next predicted word.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid_m && out_ready) begin
                if (q_m.size() == 0) check("msb_unexpected_word", 32'(q_m.size()), 32'd1);
                else check("msb_word", 32'(data_m), 32'(q_m.pop_front()));
            end
            if (valid_l && out_ready) begin
                if (q_l.size() == 0) check("lsb_unexpected_word", 32'(q_l.size()), 32'd1);
                else check("lsb_word", 32'(data_l), 32'(q_l.pop_front()));
            end
        end
    end

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; serial_in = 1'b0; out_ready = 1'b0;
        tick(2);
        check("rst_data_m", 32'(data_m), 32'h0);
        check("rst_valid_m", 32'(valid_m), 32'h0);
        check("rst_cnt_m", 32'(cnt_m), 32'h0);
        check("rst_ovr_m", 32'(ovr_m), 32'h0);
        check("rst_valid_l", 32'(valid_l), 32'h0);
        reset = 1'b0;
        tick(1);

        // Basic word, both bit orders
        send_word(8'hB1, 1'b1, 1'b0);
        check("b1_valid_m", 32'(valid_m), 32'h1);
        check("b1_data_m", 32'(data_m), 32'hB1);
        check("b1_data_l", 32'(data_l), 32'h8D);
        check("b1_cnt_m", 32'(cnt_m), 32'h0);
        tick(2);
        check("b1_stable_m", 32'(data_m), 32'hB1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("b1_drained_m", 32'(valid_m), 32'h0);
        check("b1_hold_data_m", 32'(data_m), 32'hB1);

        // Gapped input
        q_m.push_back(8'hB1); q_l.push_back(8'h8D);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        for (int g = 0; g < 3; g++) begin
            check("gap_cnt_m", 32'(cnt_m), 32'h4);
            check("gap_cnt_l", 32'(cnt_l), 32'h4);
            tick(1);
        end
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        check("gap_data_m", 32'(data_m), 32'hB1);
        check("gap_data_l", 32'(data_l), 32'h8D);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;

        // Backpressure and overrun; second word is dropped
        send_word(8'hB1, 1'b1, 1'b0);
        check("bp_ovr_mid_m", 32'(ovr_m), 32'h0);
        send_word(8'h5A, 1'b0, 1'b0);
        check("bp_data_m", 32'(data_m), 32'hB1);
        check("bp_data_l", 32'(data_l), 32'h8D);
        check("bp_valid_m", 32'(valid_m), 32'h1);
        check("bp_ovr_m", 32'(ovr_m), 32'h1);
        check("bp_ovr_l", 32'(ovr_l), 32'h1);
        check("bp_cnt_m", 32'(cnt_m), 32'h0);
        tick(2);
        check("bp_ovr_sticky_m", 32'(ovr_m), 32'h1);
        clear = 1'b1;
        send_bit(1'b1);
        clear = 1'b0;
        q_m.delete(); q_l.delete();
        check("clr_valid_m", 32'(valid_m), 32'h0);
        check("clr_ovr_m", 32'(ovr_m), 32'h0);
        check("clr_cnt_m", 32'(cnt_m), 32'h0);
        check("clr_data_m", 32'(data_m), 32'h0);

        // Completion and consumption on the same edge
        send_word(8'h12, 1'b1, 1'b0);
        send_word(8'h34, 1'b1, 1'b1);
        check("sim_valid_m", 32'(valid_m), 32'h1);
        check("sim_data_m", 32'(data_m), 32'h34);
        check("sim_data_l", 32'(data_l), 32'(rev8(8'h34)));
        check("sim_ovr_m", 32'(ovr_m), 32'h0);
        send_word(8'h56, 1'b1, 1'b1);
        tick(2);
        check("sim_ovr_end_m", 32'(ovr_m), 32'h0);
        check("sim_ovr_end_l", 32'(ovr_l), 32'h0);
        check("sim_drained_m", 32'(valid_m), 32'h0);
        out_ready = 1'b0;

        // Asynchronous reset mid-word
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("mid_cnt_m", 32'(cnt_m), 32'h5);
        #2 reset = 1'b1;
        #1;
        check("arst_cnt_m", 32'(cnt_m), 32'h0);
        check("arst_data_m", 32'(data_m), 32'h0);
        tick(1);
        reset = 1'b0;
        send_word(8'hC3, 1'b1, 1'b0);
        check("c3_data_m", 32'(data_m), 32'hC3);
        check("c3_data_l", 32'(data_l), 32'hC3);
        check("c3_valid_m", 32'(valid_m), 32'h1);
        out_ready = 1'b1;
        tick(2);

        check("left_m", 32'(q_m.size()), 32'h0);
        check("left_l", 32'(q_l.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
